gbe_udp_tx_framer: RTL
======================

# gbe_udp_tx_framer

Application-side source for the 10GbE/1GbE UDP core's application TX interface (`app_tx_*`). The block accepts a 32-bit word stream with a valid/ready handshake and per-packet destination IP/port. It serialises each word MSB-first into bytes, frames packets with `app_tx_eof`, and throttles on `app_tx_afull`. It truncates over-length packets, and keeps packet, truncation and overflow status for software.

## Interface
Parameters:
- `MAX_WORDS`, default 256: maximum payload words per emitted packet (1024 bytes); range 1..65535.
- `CNT_WIDTH`, default 32: width of the status counters.

Ports (one clock; reset is asynchronous and active-low):
- `app_clk`  in  1  sole clock.
- `app_rst_n`  in  1  asynchronous active-low reset.
- `src_data`  in  32  payload word; byte 0 is `[31:24]`.
- `src_valid`  in  1  word valid.
- `src_last`  in  1  word is the last of its packet.
- `src_destip`  in  32  destination IP; sampled with the first word of each packet.
- `src_destport`  in  16  destination UDP port; sampled with the first word.
- `src_ready`  out  1  word accepted when `src_valid & src_ready` at a rising edge.
- `app_tx_data`  out  8  byte to core.
- `app_tx_dvld`  out  1  byte valid.
- `app_tx_eof`  out  1  last byte of packet; qualified by `app_tx_dvld`.
- `app_tx_destip`  out  32  destination IP, valid with every `app_tx_dvld`.
- `app_tx_destport`  out  16  destination port, valid with every `app_tx_dvld`.
- `app_tx_afull`  in  1  core TX FIFO almost full.
- `app_tx_overflow`  in  1  core TX FIFO overflowed.
- `clr`  in  1  synchronous clear of the counters and the sticky flag.
- `pkt_count`  out  `CNT_WIDTH`  packets emitted, counted at eof bytes.
- `trunc_count`  out  `CNT_WIDTH`  packets truncated.
- `overflow_seen`  out  1  sticky flag, set by `app_tx_overflow`.

## Operation
**Word holding register.** A single register, `hold`, stores:
- `data`, `last`, `destip`, `destport`;
- a `full` flag;
- a byte index `bidx` (2 bits).

**Acceptance.**
- `src_ready = !full | (emit & bidx==3)`. It is combinational and equals 1 while `app_rst_n` is low.
- Words are not accepted while `app_rst_n` is low.

**Packet state.**
- `first` flag: 1 after reset and after accepting a `src_last` word. A word accepted with `first=1` latches `src_destip`/`src_destport`. Later words of the same packet inherit the latched destination.
- `wcnt` (16 bits): words accepted in the current packet. It resets to 0 when a packet starts.

**Truncation.**
- Trigger: a word is accepted as word number `MAX_WORDS` and `src_last=0`.
- That word is stored with `last` forced to 1, and `trunc_count` increments.
- `drop` is set. While `drop=1`, accepted words are discarded, with `src_ready=1` and no `hold` load.
- An accepted `src_last` clears `drop` and sets `first`.

**Emission.** `emit = full & !app_tx_afull`. On each emit, on the next edge:
- `app_tx_data` <= `data[31-8*bidx -: 8]`;
- `app_tx_dvld` <= 1;
- `app_tx_eof` <= (`last` & `bidx==3`);
- destip/destport outputs <= the held values;
- `bidx` <= `bidx+1`.

When no emit occurs, `app_tx_dvld` and `app_tx_eof` are registered to 0. `app_tx_data` and the destination outputs hold their last values.

**Status.**
- `pkt_count` += 1 on each registered eof byte.
- Counters wrap modulo 2^`CNT_WIDTH`.
- `overflow_seen` is set while `app_tx_overflow` is 1.
- `clr` zeroes both counters and `overflow_seen`. A same-cycle increment or set wins over `clr`: the result is 1 and set, respectively.

## Timing
- **Reset (async assert):** all outputs are 0 except `src_ready`=1. `full=0`, `first=1`, `drop=0`, `wcnt=0`, `bidx=0`.
  - Reset mid-packet discards the held word with no eof.
  - After release, the next accepted word starts a new packet.
- **Latency:** a word accepted at edge N produces its byte 0 at edge N+1 (output visible after N+1) if `app_tx_afull=0`.
- **Throughput:** one byte per cycle; one word per 4 cycles. Back-to-back words and packets have no gap cycles.
- **Backpressure:** `app_tx_afull` is sampled combinationally each cycle.
  - Afull high for k cycles inserts exactly k cycles with `dvld=0`.
  - Afull does not reorder, drop or duplicate bytes.
- **`MAX_WORDS`=1:** every packet is a single word. A multi-word source packet counts as truncated.
- **Last word at the limit:** a `src_last` word arriving exactly at word `MAX_WORDS` is a normal packet, not a truncation.

## Test plan
- **Basic packet:** 2-word packet (`0x11223344`, `0x55667788` with last), destip `0x0A000001`, port `0x2710`, afull=0 → bytes 11..88 on consecutive cycles; eof only on 88; destip/port constant on all 8 bytes; `pkt_count`=1.
- **Backpressure:** same packet with afull high for 3 cycles after byte 2 → byte stream identical; exactly 3 idle cycles; `src_ready` low until the byte-3 emit of word 0.
- **Back-to-back packets:** two 1-word packets with different destip → 8 contiguous dvld cycles; destip switches exactly at byte 4; 2 eofs; `pkt_count`=2.
- **Truncation:** `MAX_WORDS`=4, 6-word packet, then a 1-word packet → 16 bytes with eof on byte 16; words 5–6 accepted and dropped; `trunc_count`=1; next packet emitted normally; `pkt_count`=2.
- **Status:** pulse `app_tx_overflow` → `overflow_seen`=1; `clr` alone → 0; `clr` coincident with overflow → stays 1; `clr` coincident with an eof → `pkt_count`=1.
- **Reset mid-packet:** assert `app_rst_n` low during byte 2 of a word → outputs 0 immediately; after release a new 1-word packet emits 4 bytes with its own destip and eof.

Source files
------------

// File: rtl/gbe_udp_tx_framer.sv
// Application-side TX source for the UDP core: serialises 32-bit words MSB-first into
// bytes, frames packets with eof, throttles on afull, truncates over-length packets.
module gbe_udp_tx_framer #(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 app_clk,
    input  logic                 app_rst_n,
    input  logic [31:0]          src_data,
    input  logic                 src_valid,
    input  logic                 src_last,
    input  logic [31:0]          src_destip,
    input  logic [15:0]          src_destport,
    output logic                 src_ready,
    output logic [7:0]           app_tx_data,
    output logic                 app_tx_dvld,
    output logic                 app_tx_eof,
    output logic [31:0]          app_tx_destip,
    output logic [15:0]          app_tx_destport,
    input  logic                 app_tx_afull,
    input  logic                 app_tx_overflow,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] trunc_count,
    output logic                 overflow_seen
);

    localparam logic [15:0]          MAX_W   = 16'(MAX_WORDS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        PK_FIRST = 2'd0,
        PK_BODY  = 2'd1,
        PK_DROP  = 2'd2
    } pk_state_t;

    pk_state_t   pk_state_r;
    pk_state_t   pk_state_s;

    logic [31:0] hold_data_r;
    logic        hold_last_r;
    logic [31:0] hold_destip_r;
    logic [15:0] hold_destport_r;
    logic        hold_full_r;
    logic [1:0]  hold_bidx_r;

    logic [31:0] pkt_destip_r;
    logic [15:0] pkt_destport_r;
    logic [15:0] wcnt_r;

    logic        emit_s;
    logic        word_done_s;
    logic        accept_s;
    logic        load_s;
    logic        trunc_s;
    logic [15:0] wnum_s;
    logic [31:0] dest_ip_s;
    logic [15:0] dest_port_s;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_sel = word[31:24];
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
    endfunction

    assign emit_s      = hold_full_r & ~app_tx_afull;
    assign word_done_s = emit_s & (hold_bidx_r == 2'd3);
    // Words of a dropped tail are swallowed regardless of the holding register.
    assign src_ready   = (pk_state_r == PK_DROP) | ~hold_full_r | word_done_s;
    assign accept_s    = src_valid & src_ready;
    assign wnum_s      = wcnt_r + 16'd1;

    // Packet FSM next state, hold-load and truncation decode
    always_comb begin
        pk_state_s  = pk_state_r;
        load_s      = 1'b0;
        trunc_s     = 1'b0;
        dest_ip_s   = pkt_destip_r;
        dest_port_s = pkt_destport_r;
        case (pk_state_r)
            PK_FIRST, PK_BODY: begin
                if (pk_state_r == PK_FIRST) begin
                    dest_ip_s   = src_destip;
                    dest_port_s = src_destport;
                end else begin
                    dest_ip_s   = pkt_destip_r;
                    dest_port_s = pkt_destport_r;
                end
                if (accept_s) begin
                    load_s  = 1'b1;
                    trunc_s = ~src_last & (wnum_s == MAX_W);
                    if (src_last) begin
                        pk_state_s = PK_FIRST;
                    end else if (trunc_s) begin
                        pk_state_s = PK_DROP;
                    end else begin
                        pk_state_s = PK_BODY;
                    end
                end else begin
                    pk_state_s = pk_state_r;
                end
            end
            PK_DROP: begin
                if (accept_s & src_last) begin
                    pk_state_s = PK_FIRST;
                end else begin
                    pk_state_s = PK_DROP;
                end
            end
            default: begin
                pk_state_s = PK_FIRST;
            end
        endcase
    end

    // Packet FSM state register
    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) begin
            pk_state_r <= PK_FIRST;
        end else begin
            pk_state_r <= pk_state_s;
        end
    end

    // Per-packet destination latch and word counter
    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) begin
            pkt_destip_r   <= 32'd0;
            pkt_destport_r <= 16'd0;
            wcnt_r         <= 16'd0;
        end else if (load_s) begin
            pkt_destip_r   <= dest_ip_s;
            pkt_destport_r <= dest_port_s;
            wcnt_r         <= (src_last | trunc_s) ? 16'd0 : wnum_s;
        end
    end

    // Word holding register: load a new word or step the byte index on emit
    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) begin
            hold_data_r     <= 32'd0;
            hold_last_r     <= 1'b0;
            hold_destip_r   <= 32'd0;
            hold_destport_r <= 16'd0;
            hold_full_r     <= 1'b0;
            hold_bidx_r     <= 2'd0;
        end else if (load_s) begin
            hold_data_r     <= src_data;
            hold_last_r     <= src_last | trunc_s;
            hold_destip_r   <= dest_ip_s;
            hold_destport_r <= dest_port_s;
            hold_full_r     <= 1'b1;
            hold_bidx_r     <= 2'd0;
        end else if (emit_s) begin
            hold_full_r     <= (hold_bidx_r != 2'd3);
            hold_bidx_r     <= hold_bidx_r + 2'd1;
        end
    end

    // Registered byte interface towards the core; data/dest hold while idle
    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) begin
            app_tx_data     <= 8'd0;
            app_tx_dvld     <= 1'b0;
            app_tx_eof      <= 1'b0;
            app_tx_destip   <= 32'd0;
            app_tx_destport <= 16'd0;
        end else if (emit_s) begin
            app_tx_data     <= byte_sel(hold_data_r, hold_bidx_r);
            app_tx_dvld     <= 1'b1;
            app_tx_eof      <= hold_last_r & (hold_bidx_r == 2'd3);
            app_tx_destip   <= hold_destip_r;
            app_tx_destport <= hold_destport_r;
        end else begin
            app_tx_dvld     <= 1'b0;
            app_tx_eof      <= 1'b0;
        end
    end

    // Status counters and sticky overflow flag; an event in the clr cycle survives it
    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) begin
            pkt_count     <= CNT_ZERO;
            trunc_count   <= CNT_ZERO;
            overflow_seen <= 1'b0;
        end else begin
            if (app_tx_eof) begin
                pkt_count <= clr ? CNT_ONE : pkt_count + CNT_ONE;
            end else if (clr) begin
                pkt_count <= CNT_ZERO;
            end
            if (trunc_s) begin
                trunc_count <= clr ? CNT_ONE : trunc_count + CNT_ONE;
            end else if (clr) begin
                trunc_count <= CNT_ZERO;
            end
            if (app_tx_overflow) begin
                overflow_seen <= 1'b1;
            end else if (clr) begin
                overflow_seen <= 1'b0;
            end
        end
    end

endmodule
